hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage MIPS pipeline; producer of load_stop_request.
//  Detects load-use hazards (EX load feeding an ID source), data-memory wait cycles and taken branches.
//  Drives per-stage hold/bubble/flush signals into PC, IF_ID, ID_EX and EX_MEM.
//  Tracks memory-wait timeout (sticky error) and counts stall cycles for performance tests.
// PARAMETERS
//  MEM_TIMEOUT   16   max consecutive memory-wait cycles before entering ERROR (>=2)
//  CNT_W         32   width of stall_count
// PORTS
//  clk                input   1   single clock, all state on posedge
//  rst                input   1   reset; one clock, reset is synchronous and active-high
//  id_rsRead          input   1   ID instruction reads rs
//  id_rsAddr          input   5   ID rs index
//  id_rtRead          input   1   ID instruction reads rt
//  id_rtAddr          input   5   ID rt index
//  ex_isLoad          input   1   EX-stage instruction is a load
//  ex_regWriteAddr    input   5   EX-stage destination register
//  id_branchTaken     input   1   branch/jump resolved taken in ID
//  mem_req            input   1   MEM stage has an access in flight
//  mem_ready          input   1   data memory completes access this cycle
//  pc_stall           output  1   hold PC
//  if_id_stall        output  1   hold IF_ID
//  if_id_flush        output  1   zero IF_ID (squash fetched instruction)
//  load_stop_request  output  1   insert bubble into ID_EX (ID_EX loads zeros)
//  id_ex_stall        output  1   hold ID_EX contents
//  ex_mem_stall       output  1   hold EX_MEM contents
//  mem_timeout_err    output  1   sticky: memory wait exceeded MEM_TIMEOUT
//  stall_count        output  CNT_W  cycles with pc_stall=1, saturating
// BEHAVIOUR
//  Reset: state=RUN, wait_timer=0, mem_timeout_err=0, stall_count=0; while rst=1 all stall/flush outputs 0.
//  mem_wait = mem_req & ~mem_ready (comb). load_use = ex_isLoad & ex_regWriteAddr!=0 &
//   ((id_rsRead & id_rsAddr==ex_regWriteAddr) | (id_rtRead & id_rtAddr==ex_regWriteAddr)) (comb).
//  All stall/flush outputs combinational, zero-latency: valid in the cycle the condition is present.
//  FSM states: RUN, MEM_WAIT, ERROR.
//   RUN: mem_wait -> MEM_WAIT, wait_timer<=1. Else stay.
//   MEM_WAIT: mem_ready -> RUN, wait_timer<=0. Else wait_timer++; wait_timer==MEM_TIMEOUT-1 & ~mem_ready
//    -> ERROR, mem_timeout_err<=1.
//   ERROR: absorbing until rst; mem_ready ignored.
//  Priority (highest first), same cycle:
//   1 ERROR or mem_wait (RUN or MEM_WAIT): pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1;
//     load_stop_request=0 (hold, not bubble); if_id_flush=0.
//   2 load_use: pc_stall=if_id_stall=1, load_stop_request=1, id_ex_stall=ex_mem_stall=0, if_id_flush=0.
//   3 id_branchTaken: if_id_flush=1 only; nothing stalled.
//   4 otherwise all 0.
//  Branch with load_use: branch stays in ID, re-evaluated next cycle; flush issued when it advances.
//  Load_use and mem_wait together: mem_wait wins; load_use re-evaluated after wait ends (EX held).
//  mem_ready in the same cycle mem_req rises: no wait, state stays RUN.
//  stall_count += 1 each cycle pc_stall=1, saturates at all-ones, no wrap; cleared only by rst.
//  rst mid-MEM_WAIT or in ERROR: returns to RUN next edge, error and counter cleared.
// STRUCTURE
//  Shared package/header pipe_defs: state encodings ST_RUN/ST_MEM_WAIT/ST_ERROR, REG_ZERO=5'd0.
//  One sub-module: load_use_detect (pure comb compare) producing load_use; FSM, timer and counter stay here.
// TESTING
//  1 ex_isLoad=1,ex_regWriteAddr=8,id_rsRead=1,id_rsAddr=8 for 1 cycle -> load_stop_request,pc_stall,if_id_stall=1 same cycle; id_ex_stall=0.
//  2 same but ex_regWriteAddr=0 or id_rtRead=0 with id_rtAddr=8 only -> no stall.
//  3 mem_req=1,mem_ready=0 for 3 cycles then ready -> all four stalls high 3 cycles, load_stop_request=0, stall_count=3, state RUN.
//  4 MEM_TIMEOUT=4, mem_ready held 0 -> ERROR after 4th wait cycle, mem_timeout_err=1 sticky; rst clears to 0.
//  5 id_branchTaken=1 with load_use=1 -> if_id_flush=0; next cycle load_use=0 -> if_id_flush=1, no stalls.
//  6 force stall_count=2^CNT_W-2, stall 3 cycles -> saturates at all-ones; rst asserted mid-MEM_WAIT -> outputs 0, count 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall FSM encodings, the hard-wired zero register,
// and the bundle of per-stage hold/bubble/flush controls.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic load_stop_request;
        logic id_ex_stall;
        logic ex_mem_stall;
    } ctrl_t;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: EX load whose non-zero destination matches a source read in ID.
// Pure combinational, zero latency.
module load_use_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic       id_rsRead,
    input  logic [4:0] id_rsAddr,
    input  logic       id_rtRead,
    input  logic [4:0] id_rtAddr,
    input  logic       ex_isLoad,
    input  logic [4:0] ex_regWriteAddr,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_rsRead && (id_rsAddr == ex_regWriteAddr);
    assign rt_hit   = id_rtRead && (id_rtAddr == ex_regWriteAddr);
    assign load_use = ex_isLoad && (ex_regWriteAddr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: load-use bubbles, memory-wait holds, branch flushes,
// memory-wait timeout tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rsRead,
    input  logic [4:0]       id_rsAddr,
    input  logic             id_rtRead,
    input  logic [4:0]       id_rtAddr,
    input  logic             ex_isLoad,
    input  logic [4:0]       ex_regWriteAddr,
    input  logic             id_branchTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             load_stop_request,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    wait_timer_q, wait_timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_wait;
    logic             load_use;
    ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .id_rsRead       (id_rsRead),
        .id_rsAddr       (id_rsAddr),
        .id_rtRead       (id_rtRead),
        .id_rtAddr       (id_rtAddr),
        .ex_isLoad       (ex_isLoad),
        .ex_regWriteAddr (ex_regWriteAddr),
        .load_use        (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        state_d      = state_q;
        wait_timer_d = wait_timer_q;
        err_d        = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d      = ST_MEM_WAIT;
                    wait_timer_d = TW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d      = ST_RUN;
                    wait_timer_d = '0;
                end else begin
                    wait_timer_d = wait_timer_q + TW'(1);
                    if (wait_timer_q == TW'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ERROR: ;
            default: state_d = ST_RUN;
        endcase
    end

    // Hold beats bubble: while the memory stalls, EX must keep its load rather than lose it.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            if (state_q == ST_ERROR || mem_wait) begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_stall = 1'b1;
            end else if (load_use) begin
                ctrl.pc_stall          = 1'b1;
                ctrl.if_id_stall       = 1'b1;
                ctrl.load_stop_request = 1'b1;
            end else if (id_branchTaken) begin
                ctrl.if_id_flush = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ctrl.pc_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wait_timer_q <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            wait_timer_q <= wait_timer_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pc_stall          = ctrl.pc_stall;
    assign if_id_stall       = ctrl.if_id_stall;
    assign if_id_flush       = ctrl.if_id_flush;
    assign load_stop_request = ctrl.load_stop_request;
    assign id_ex_stall       = ctrl.id_ex_stall;
    assign ex_mem_stall      = ctrl.ex_mem_stall;
    assign mem_timeout_err   = err_q;
    assign stall_count       = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; small counter width so saturation is reachable.
module tb_hazard_stall_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    // Control bit order: pc, if_id_stall, if_id_flush, load_stop, id_ex_stall, ex_mem_stall
    localparam logic [5:0] K_NONE = 6'b000000;
    localparam logic [5:0] K_HOLD = 6'b110011;
    localparam logic [5:0] K_LU   = 6'b110100;
    localparam logic [5:0] K_FL   = 6'b001000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_rsRead = 1'b0;
    logic [4:0]       id_rsAddr = '0;
    logic             id_rtRead = 1'b0;
    logic [4:0]       id_rtAddr = '0;
    logic             ex_isLoad = 1'b0;
    logic [4:0]       ex_regWriteAddr = '0;
    logic             id_branchTaken = 1'b0;
    logic             mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_stall, if_id_stall, if_id_flush, load_stop_request;
    logic             id_ex_stall, ex_mem_stall, mem_timeout_err;
    logic [CNT_W-1:0] stall_count;

    logic [CNT_W+6:0] exp_q[$];
    string            name_q[$];
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rsRead         (id_rsRead),
        .id_rsAddr         (id_rsAddr),
        .id_rtRead         (id_rtRead),
        .id_rtAddr         (id_rtAddr),
        .ex_isLoad         (ex_isLoad),
        .ex_regWriteAddr   (ex_regWriteAddr),
        .id_branchTaken    (id_branchTaken),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .load_stop_request (load_stop_request),
        .id_ex_stall       (id_ex_stall),
        .ex_mem_stall      (ex_mem_stall),
        .mem_timeout_err   (mem_timeout_err),
        .stall_count       (stall_count)
    );

    task automatic step(input logic r, input logic rsr, input logic [4:0] rsa,
                        input logic rtr, input logic [4:0] rta, input logic ld,
                        input logic [4:0] wa, input logic br, input logic req,
                        input logic rdy, input logic [5:0] ctl, input logic err,
                        input logic [CNT_W-1:0] cnt, input string name);
        @(posedge clk);
        #1;
        rst = r; id_rsRead = rsr; id_rsAddr = rsa; id_rtRead = rtr; id_rtAddr = rta;
        ex_isLoad = ld; ex_regWriteAddr = wa; id_branchTaken = br;
        mem_req = req; mem_ready = rdy;
        exp_q.push_back({ctl, err, cnt});
        name_q.push_back(name);
    endtask

    // Monitor: every cycle with a pending expectation, compare mid-cycle
    initial begin
        logic [CNT_W+6:0] e, act;
        string            n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = {pc_stall, if_id_stall, if_id_flush, load_stop_request,
                       id_ex_stall, ex_mem_stall, mem_timeout_err, stall_count};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: ctl/err/cnt got %b want %b", n, act, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        step(1, 1, 8, 0, 0, 1, 8, 0, 1, 0, K_NONE, 0, 0, "rst_quiet");
        step(0, 1, 8, 0, 0, 1, 8, 0, 0, 0, K_LU,   0, 0, "lu_rs");
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, K_NONE, 0, 1, "lu_r0");
        step(0, 0, 0, 0, 8, 1, 8, 0, 0, 0, K_NONE, 0, 1, "rt_noread");
        step(0, 0, 0, 1, 8, 1, 8, 0, 0, 0, K_LU,   0, 1, "lu_rt");
        step(0, 1, 9, 1, 7, 1, 8, 0, 0, 0, K_NONE, 0, 2, "lu_miss");
        step(0, 1, 8, 0, 0, 0, 8, 0, 0, 0, K_NONE, 0, 2, "no_load");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 2, "mw1");
        step(0, 1, 8, 0, 0, 1, 8, 0, 1, 0, K_HOLD, 0, 3, "mw2_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 4, "mw3");
        step(0, 1, 8, 0, 0, 1, 8, 0, 1, 1, K_LU,   0, 5, "mw_done_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, K_NONE, 0, 6, "req_rdy");
        step(0, 1, 8, 0, 0, 1, 8, 1, 0, 0, K_LU,   0, 6, "br_lu");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, K_FL,   0, 7, "br");
        step(0, 1, 8, 0, 0, 1, 8, 0, 0, 0, K_LU,   0, 7, "sat_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 7, "to1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 7, "to2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 7, "to3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 7, "to4");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, K_HOLD, 1, 7, "err_rdy_ign");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, K_HOLD, 1, 7, "err_br");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_NONE, 1, 7, "rst_err");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_NONE, 0, 0, "post_rst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 0, "mw_a");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 1, "mw_b");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_NONE, 0, 2, "rst_mw");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_NONE, 0, 0, "run_again");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 0, "rt1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 1, "rt2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 2, "rt3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, K_HOLD, 0, 3, "rt4");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_HOLD, 1, 4, "rt_err");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
